pupil_centroid: RTL and testbench

Upstream stage of the eye-tracking pipeline. It consumes the raster pixel stream from the eye-facing camera interface and thresholds dark pixels. It computes the pupil centroid once per frame and presents the coordinate hint, with a one-cycle valid strobe, to the depth-search stage downstream. All arithmetic uses integer accumulators plus a shared sequential divider, so no multipliers are needed.

---
 rtl/eye_pkg.sv | 22 ++
 rtl/seq_divider.sv | 65 ++++++
 rtl/pupil_centroid.sv | 143 ++++++++++++++
 tb/tb_pupil_centroid.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/eye_pkg.sv
// Shared constants and FSM state type for the eye-tracking front end.
// Coordinate, accumulator and count widths are sized for the default 112x112 raster.
package eye_pkg;

    localparam int IMG_W_DEF     = 112;
    localparam int IMG_H_DEF     = 112;
    localparam int PIX_W_DEF     = 8;
    localparam int MIN_COUNT_DEF = 16;

    localparam int COORD_W = 7;
    localparam int SUM_W   = 21;
    localparam int CNT_W   = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DIV_X,
        ST_DIV_Y,
        ST_DONE
    } state_e;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, SUM_W cycles per divide.
// The first step runs on the start edge, so done_o is high in the cycle after the last step.
module seq_divider
    import eye_pkg::*;
(
    input  logic               clk,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               start_i,
    input  logic [SUM_W-1:0]   dividend_i,
    input  logic [CNT_W-1:0]   divisor_i,
    output logic               done_o,
    output logic [COORD_W-1:0] quotient_o
);

    localparam int STEP_W = $clog2(SUM_W + 1);

    logic [STEP_W-1:0] steps_q;
    logic [CNT_W-1:0]  rem_q, rem_d, div_q, src_rem, src_div;
    logic [SUM_W-1:0]  quo_q, quo_d, src_quo;
    logic [CNT_W:0]    trial, diff;
    logic              fits, done_q;

    // The remainder stays below the divisor, so it fits CNT_W bits; the borrow bit decides the step.
    always_comb begin
        src_rem = start_i ? '0 : rem_q;
        src_quo = start_i ? dividend_i : quo_q;
        src_div = start_i ? divisor_i : div_q;
        trial   = {src_rem, src_quo[SUM_W-1]};
        diff    = trial - {1'b0, src_div};
        fits    = ~diff[CNT_W];
        rem_d   = fits ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
        quo_d   = {src_quo[SUM_W-2:0], fits};
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            steps_q <= '0;
            done_q  <= 1'b0;
        end else if (start_i) begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= divisor_i;
            steps_q <= STEP_W'(SUM_W - 1);
            done_q  <= 1'b0;
        end else if (clear_i) begin
            steps_q <= '0;
            done_q  <= 1'b0;
        end else if (steps_q != '0) begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            steps_q <= steps_q - STEP_W'(1);
            done_q  <= (steps_q == STEP_W'(1));
        end else begin
            done_q  <= 1'b0;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q[COORD_W-1:0];

endmodule

// File: rtl/pupil_centroid.sv
// Thresholds dark pixels of a raster frame and reports their centroid once per frame.
// Coordinate sums are divided by the dark count with one shared sequential divider (X then Y).
module pupil_centroid
    import eye_pkg::*;
#(
    parameter int IMG_W     = IMG_W_DEF,
    parameter int IMG_H     = IMG_H_DEF,
    parameter int PIX_W     = PIX_W_DEF,
    parameter int MIN_COUNT = MIN_COUNT_DEF
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               sof,
    input  logic               pix_valid,
    input  logic [PIX_W-1:0]   pix_data,
    input  logic [PIX_W-1:0]   threshold,
    output logic [COORD_W-1:0] pupil_x,
    output logic [COORD_W-1:0] pupil_y,
    output logic               pupil_found,
    output logic               pupil_valid,
    output logic               busy,
    output state_e             dbg_state
);

    state_e             state_q;
    logic [PIX_W-1:0]   thr_q, thr_d;
    logic [COORD_W-1:0] col_q, col_d, col_b;
    logic [COORD_W-1:0] row_q, row_d, row_b;
    logic [SUM_W-1:0]   sum_x_q, sum_x_d, sx_b;
    logic [SUM_W-1:0]   sum_y_q, sum_y_d, sy_b;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_b;
    logic [COORD_W-1:0] quo_x_q, x_q, y_q;
    logic               found_q, valid_q;
    logic               accept, dark, last_pix, enough;
    logic               div_start, div_done;
    logic [SUM_W-1:0]   div_dividend;
    logic [COORD_W-1:0] div_quo;

    // sof clears the frame state in the same cycle, so a coincident pixel is (0,0) under the new threshold.
    always_comb begin
        thr_d  = sof ? threshold : thr_q;
        col_b  = sof ? '0 : col_q;
        row_b  = sof ? '0 : row_q;
        sx_b   = sof ? '0 : sum_x_q;
        sy_b   = sof ? '0 : sum_y_q;
        cnt_b  = sof ? '0 : cnt_q;
        accept = pix_valid && (sof || state_q == ST_ACCUM);
        dark   = accept && (pix_data < thr_d);

        sum_x_d = sx_b + (dark ? SUM_W'(col_b) : '0);
        sum_y_d = sy_b + (dark ? SUM_W'(row_b) : '0);
        cnt_d   = cnt_b + CNT_W'(dark);

        col_d = col_b;
        row_d = row_b;
        if (accept) begin
            if (col_b == COORD_W'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_b == COORD_W'(IMG_H - 1)) ? '0 : row_b + COORD_W'(1);
            end else begin
                col_d = col_b + COORD_W'(1);
            end
        end

        last_pix     = accept && (col_b == COORD_W'(IMG_W - 1)) && (row_b == COORD_W'(IMG_H - 1));
        enough       = (cnt_d >= CNT_W'(MIN_COUNT));
        div_start    = (last_pix && enough) || (state_q == ST_DIV_X && div_done && !sof);
        div_dividend = (state_q == ST_DIV_X) ? sum_y_q : sum_x_d;
    end

    seq_divider u_div (
        .clk        (clk),
        .rst_i      (reset),
        .clear_i    (sof),
        .start_i    (div_start),
        .dividend_i (div_dividend),
        .divisor_i  (cnt_d),
        .done_o     (div_done),
        .quotient_o (div_quo)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            thr_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q   <= '0;
            quo_x_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            found_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            thr_q   <= thr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
            cnt_q   <= cnt_d;
            valid_q <= 1'b0;
            if (last_pix) begin
                if (enough) begin
                    state_q <= ST_DIV_X;
                end else begin
                    state_q <= ST_DONE;
                    found_q <= 1'b0;
                    valid_q <= 1'b1;
                end
            end else if (sof) begin
                state_q <= ST_ACCUM;
            end else begin
                case (state_q)
                    ST_DIV_X: if (div_done) begin
                        quo_x_q <= div_quo;
                        state_q <= ST_DIV_Y;
                    end
                    // X is parked until Y finishes so all result outputs change together.
                    ST_DIV_Y: if (div_done) begin
                        x_q     <= quo_x_q;
                        y_q     <= div_quo;
                        found_q <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                    ST_DONE: state_q <= ST_IDLE;
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign pupil_x     = x_q;
    assign pupil_y     = y_q;
    assign pupil_found = found_q;
    assign pupil_valid = valid_q;
    assign busy        = (state_q == ST_DIV_X) || (state_q == ST_DIV_Y) || (state_q == ST_DONE);
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pupil_centroid.sv
// Frame-level bench for pupil_centroid: frames are built in an image array, a reference
// model computes centroid and result cycle, and a monitor compares every pupil_valid strobe.
module tb_pupil_centroid;
  import eye_pkg::*;

  localparam int W      = 112;
  localparam int H      = 112;
  localparam int NPIX   = W * H;
  localparam int MINC   = 16;
  localparam int EXP_W  = 47;

  // Handshake: no backpressure; each pupil_valid strobe is one result that must match
  // the oldest entry of exp_q, packed as {cycle[31:0], found, x[6:0], y[6:0]}.

  logic       clk = 1'b0;
  logic       reset;
  logic       sof;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic [7:0] threshold;
  logic [6:0] pupil_x;
  logic [6:0] pupil_y;
  logic       pupil_found;
  logic       pupil_valid;
  logic       busy;
  state_e     dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] mon_e;
  logic [7:0]       img [0:NPIX-1];
  int               cyc = 0;
  int               n_tests = 0;
  int               n_fail = 0;
  int               m_x = 0;
  int               m_y = 0;

  pupil_centroid dut (
    .clk         (clk),
    .reset       (reset),
    .sof         (sof),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .threshold   (threshold),
    .pupil_x     (pupil_x),
    .pupil_y     (pupil_y),
    .pupil_found (pupil_found),
    .pupil_valid (pupil_valid),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // image builders
  task automatic fill(input logic [7:0] v);
    for (int p = 0; p < NPIX; p++) img[p] = v;
  endtask

  task automatic rect(input int c0, input int r0, input int w, input int h, input logic [7:0] v);
    for (int r = r0; r < r0 + h; r++)
      for (int c = c0; c < c0 + w; c++) img[r * W + c] = v;
  endtask

  task automatic fill_random(input logic [7:0] thr);
    int c0, r0, bw, bh;
    for (int p = 0; p < NPIX; p++) img[p] = 8'($urandom_range(int'(thr), 255));
    bw = $urandom_range(4, 12);
    bh = $urandom_range(4, 12);
    c0 = $urandom_range(0, W - bw);
    r0 = $urandom_range(0, H - bh);
    for (int r = r0; r < r0 + bh; r++)
      for (int c = c0; c < c0 + bw; c++) img[r * W + c] = 8'($urandom_range(0, int'(thr) - 1));
  endtask

  // reference model: centroid of all pixels strictly below thr, result cycle from last pixel
  task automatic push_expect(input logic [7:0] thr, input int n_last);
    int cnt, sx, sy, found, lat;
    cnt = 0; sx = 0; sy = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (img[r * W + c] < thr) begin
          cnt++;
          sx += c;
          sy += r;
        end
    found = (cnt >= MINC) ? 1 : 0;
    if (found == 1) begin
      m_x = (sx / cnt) % 128;
      m_y = (sy / cnt) % 128;
      lat = 43;
    end else begin
      lat = 1;
    end
    exp_q.push_back({32'(n_last + lat), 1'(found), 7'(m_x), 7'(m_y)});
  endtask

  // driver tasks
  task automatic drive_pixels(input logic [7:0] thr, input int npix, output int n_last);
    n_last = 0;
    for (int p = 0; p < npix; p++) begin
      @(posedge clk); #1;
      sof       = (p == 0);
      threshold = (p == 0) ? thr : 8'h00;
      pix_valid = 1'b1;
      pix_data  = img[p];
      n_last    = cyc;
    end
  endtask

  task automatic send_frame(input logic [7:0] thr, input bit expect_result);
    int n_last;
    drive_pixels(thr, NPIX, n_last);
    if (expect_result) push_expect(thr, n_last);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sof       = 1'b0;
      threshold = 8'h00;
      pix_valid = 1'($urandom_range(0, 1));
      pix_data  = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain_pending", exp_q.size(), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && pupil_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(pupil_valid), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("valid_cycle", cyc, mon_e[46:15]);
        check("found", 32'(pupil_found), 32'(mon_e[14]));
        check("pupil_x", 32'(pupil_x), 32'(mon_e[13:7]));
        check("pupil_y", 32'(pupil_y), 32'(mon_e[6:0]));
        check("busy_in_done", 32'(busy), 1);
      end
    end
  end

  initial begin
    logic [7:0] thr_r;
    int         n_last;
    reset = 1'b1;
    sof = 1'b0; pix_valid = 1'b0; pix_data = 8'h00; threshold = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(pupil_x), 0);
    check("rst_y", 32'(pupil_y), 0);
    check("rst_found", 32'(pupil_found), 0);
    check("rst_valid", 32'(pupil_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    blank(10);

    // no dark pixels: skip path
    fill(8'hFF);
    send_frame(8'h40, 1'b1);
    blank(60); drain();

    // 16 dark pixels on row 0, first one coincident with sof while threshold goes 0x00 -> 0x40
    fill(8'hFF);
    rect(0, 0, 16, 1, 8'h00);
    send_frame(8'h40, 1'b1);
    blank(60); drain();

    // pixels equal to threshold are not dark; 15 dark pixels stay below MIN_COUNT
    fill(8'hFF);
    rect(40, 60, 10, 10, 8'h40);
    rect(0, 0, 15, 1, 8'h10);
    send_frame(8'h40, 1'b1);
    blank(60); drain();

    // block frame aborted by sof 10 cycles after its last pixel, then a random frame
    fill(8'hFF);
    rect(40, 60, 10, 10, 8'h10);
    send_frame(8'h40, 1'b0);
    blank(9);
    thr_r = 8'($urandom_range(32, 192));
    fill_random(thr_r);
    send_frame(thr_r, 1'b1);
    blank(60); drain();

    // reset in the middle of a frame
    fill(8'hFF);
    rect(40, 60, 10, 10, 8'h10);
    drive_pixels(8'h40, 1500, n_last);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midrst_x", 32'(pupil_x), 0);
    check("midrst_y", 32'(pupil_y), 0);
    check("midrst_found", 32'(pupil_found), 0);
    check("midrst_valid", 32'(pupil_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    m_x = 0; m_y = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    blank(5);
    send_frame(8'h40, 1'b1);
    blank(60); drain();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
